// File: rtl/mux8_rr_sender.sv
// mux8_rr_sender: round-robin 8:1 sender for a shared m/s2..s0 bus.
// Requests are collected and the next channel is chosen round-robin after the
// last one served. The winner's data and index are held on the bus for HOLD
// cycles, with a one-cycle one-hot ack at the start of each transfer.
// All outputs are registered, so there is no combinational path from req/din.
module mux8_rr_sender #(
  parameter int DW   = 1,
  parameter int HOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      req,
  input  logic [8*DW-1:0] din,
  output logic [DW-1:0]   m,
  output logic            s0,
  output logic            s1,
  output logic            s2,
  output logic            valid,
  output logic [7:0]      ack,
  output logic            busy
);

  typedef enum logic {IDLE, SEND} state_t;

  // Counter reload: the grant cycle itself is the first of the HOLD cycles.
  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  state_t          state_reg, state_next;
  logic [7:0]      cnt_reg, cnt_next;
  logic [2:0]      last_reg, last_next;
  logic [2:0]      sel_reg, sel_next;
  logic [DW-1:0]   m_reg, m_next;
  logic            valid_reg, valid_next;
  logic [7:0]      ack_reg, ack_next;

  logic [DW-1:0]   din_ch [8];
  logic [7:0]      rot_req;
  logic [2:0]      win_off;
  logic [2:0]      win_idx;
  logic            any_req;
  logic            grant;

  // Split the flat data bus into per-channel slices and rotate the request
  // vector so that bit 0 is the channel right after the last one served.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
      assign din_ch[gi]  = din[gi*DW +: DW];
      assign rot_req[gi] = req[last_reg + 3'(gi + 1)];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the round-robin winner.
  always_comb begin
    win_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot_req[k]) win_off = 3'(k);
    end
  end

  assign win_idx = last_reg + 3'd1 + win_off;
  assign any_req = |req;
  // A new grant is allowed from IDLE, or on the final cycle of a transfer so
  // back-to-back transfers have no idle gap.
  assign grant   = any_req && ((state_reg == IDLE) || (cnt_reg == 8'd0));

  // Next-state and next-output logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    sel_next   = sel_reg;
    m_next     = m_reg;
    valid_next = valid_reg;
    ack_next   = 8'd0;
    if (grant) begin
      state_next = SEND;
      cnt_next   = HOLD_M1;
      last_next  = win_idx;
      sel_next   = win_idx;
      m_next     = din_ch[win_idx];
      valid_next = 1'b1;
      ack_next   = 8'd1 << win_idx;
    end else begin
      case (state_reg)
        IDLE: begin
          valid_next = 1'b0;
        end
        SEND: begin
          if (cnt_reg == 8'd0) begin
            state_next = IDLE;
            cnt_next   = 8'd0;
            sel_next   = 3'd0;
            m_next     = '0;
            valid_next = 1'b0;
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset puts the pointer at 7 so channel 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      last_reg  <= 3'd7;
      sel_reg   <= 3'd0;
      m_reg     <= '0;
      valid_reg <= 1'b0;
      ack_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      sel_reg   <= sel_next;
      m_reg     <= m_next;
      valid_reg <= valid_next;
      ack_reg   <= ack_next;
    end
  end

  assign m     = m_reg;
  assign s0    = sel_reg[0];
  assign s1    = sel_reg[1];
  assign s2    = sel_reg[2];
  assign valid = valid_reg;
  assign busy  = valid_reg;
  assign ack   = ack_reg;

endmodule

// File: tb/tb_mux8_rr_sender.sv
// Bench for mux8_rr_sender: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the round-robin sender.
module tb_mux8_rr_sender;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  // Main instance: DW=1, HOLD=4
  logic [7:0] req = 8'd0;
  logic [7:0] din = 8'd0;
  logic [0:0] m;
  logic       s0, s1, s2, valid, busy;
  logic [7:0] ack;

  // Second instance: DW=2, HOLD=1
  logic [7:0]  req1 = 8'd0;
  logic [15:0] din1 = 16'd0;
  logic [1:0]  m1;
  logic        s0_1, s1_1, s2_1, valid1, busy1;
  logic [7:0]  ack1;

  int checks = 0;
  int failures = 0;

  // Behavioural model state (main instance)
  bit       mdl_active;
  int       mdl_rem;
  int       mdl_last;
  int       mdl_ch;
  bit       mdl_m;
  bit [7:0] mdl_ack;

  always #5 clk = ~clk;

  mux8_rr_sender #(.DW(1), .HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .m(m), .s0(s0), .s1(s1), .s2(s2), .valid(valid), .ack(ack), .busy(busy)
  );

  mux8_rr_sender #(.DW(2), .HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .din(din1),
    .m(m1), .s0(s0_1), .s1(s1_1), .s2(s2_1), .valid(valid1), .ack(ack1), .busy(busy1)
  );

  task automatic model_reset();
    mdl_active = 0; mdl_rem = 0; mdl_last = 7; mdl_ch = 0; mdl_m = 0; mdl_ack = 0;
  endtask

  // One clock edge of the spec's behaviour, with the inputs seen at that edge.
  task automatic model_edge(input logic [7:0] r, input logic [7:0] d);
    int c;
    if (mdl_active && mdl_rem > 1) begin
      mdl_rem--;
      mdl_ack = 0;
    end else if (r != 0) begin
      c = 0;
      for (int k = 8; k >= 1; k--) begin
        if (r[(mdl_last + k) % 8]) c = (mdl_last + k) % 8;
      end
      mdl_active = 1; mdl_rem = 4; mdl_ch = c; mdl_m = d[c];
      mdl_ack = 8'd1 << c; mdl_last = c;
    end else begin
      mdl_active = 0; mdl_rem = 0; mdl_ch = 0; mdl_m = 0; mdl_ack = 0;
    end
  endtask

  // Drive inputs at the falling edge, take one rising edge, settle 1 time unit.
  task automatic cyc(input logic [7:0] r, input logic [7:0] d);
    @(negedge clk);
    req = r; din = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = 0; req1 = 0;
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req = 0; req1 = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, m, s2, s1, s0, ack, busy} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b m=%b sel=%b ack=%b busy=%b required all 0",
               valid, m, {s2, s1, s0}, ack, busy);
    end
    checks++;
    if ({valid1, m1, ack1} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs_h1: valid=%b m=%b ack=%b required all 0", valid1, m1, ack1);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    cyc(8'b0000_0001, 8'b0000_0001);
    checks++;
    if (valid !== 1'b1 || m !== 1'b1 || {s2, s1, s0} !== 3'd0 || ack !== 8'h01) begin
      failures++;
      $display("FAIL single_grant: valid=%b m=%b sel=%0d ack=%b required 1 1 0 00000001",
               valid, m, {s2, s1, s0}, ack);
    end
    for (int c = 1; c < 4; c++) begin
      cyc(8'd0, 8'd0);
      checks++;
      if (valid !== 1'b1 || m !== 1'b1 || ack !== 8'h00 || busy !== 1'b1) begin
        failures++;
        $display("FAIL single_hold c=%0d: valid=%b m=%b ack=%b busy=%b required 1 1 00000000 1",
                 c, valid, m, ack, busy);
      end
    end
    cyc(8'd0, 8'd0);
    checks++;
    if (valid !== 1'b0 || m !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_end: valid=%b m=%b busy=%b required 0 0 0", valid, m, busy);
    end
    $display("test_single done");
  endtask

  task automatic test_rr_all();
    logic [7:0] par;
    int ch;
    for (int i = 0; i < 8; i++) par[i] = ^(3'(i));
    do_reset();
    for (int k = 0; k < 36; k++) begin
      cyc(8'hFF, par);
      ch = (k / 4) % 8;
      checks++;
      if (valid !== 1'b1 || {s2, s1, s0} !== 3'(ch) || m !== par[ch] ||
          ack !== ((k % 4 == 0) ? (8'd1 << ch) : 8'd0)) begin
        failures++;
        $display("FAIL rr_all k=%0d: valid=%b sel=%0d m=%b ack=%b required 1 %0d %b %b",
                 k, valid, {s2, s1, s0}, m, ack, ch, par[ch],
                 (k % 4 == 0) ? (8'd1 << ch) : 8'd0);
      end
    end
    cyc(8'd0, par);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL rr_all_end: valid=%b required 0", valid);
    end
    $display("test_rr_all done");
  endtask

  task automatic test_din_sample();
    logic [7:0] d;
    d = 8'($urandom);
    cyc(8'h20, d);
    checks++;
    if (ack !== 8'h20 || m !== d[5] || {s2, s1, s0} !== 3'd5) begin
      failures++;
      $display("FAIL din_grant: ack=%b m=%b sel=%0d required 00100000 %b 5", ack, m, {s2, s1, s0}, d[5]);
    end
    for (int c = 1; c < 4; c++) begin
      cyc(8'd0, ~d);
      checks++;
      if (valid !== 1'b1 || m !== d[5] || {s2, s1, s0} !== 3'd5) begin
        failures++;
        $display("FAIL din_hold c=%0d: valid=%b m=%b sel=%0d required 1 %b 5",
                 c, valid, m, {s2, s1, s0}, d[5]);
      end
    end
    cyc(8'd0, ~d);
    checks++;
    if (valid !== 1'b0 || m !== 1'b0 || {s2, s1, s0} !== 3'd0) begin
      failures++;
      $display("FAIL din_end: valid=%b m=%b sel=%0d required 0 0 0", valid, m, {s2, s1, s0});
    end
    $display("test_din_sample done");
  endtask

  task automatic test_wrap();
    int exp_ch;
    cyc(8'h40, 8'($urandom));
    checks++;
    if ({s2, s1, s0} !== 3'd6 || ack !== 8'h40) begin
      failures++;
      $display("FAIL wrap_first: sel=%0d ack=%b required 6 01000000", {s2, s1, s0}, ack);
    end
    for (int st = 1; st <= 12; st++) begin
      cyc(8'b1000_0011, 8'($urandom));
      if (st % 4 == 0) begin
        exp_ch = (st == 4) ? 7 : (st == 8) ? 0 : 1;
        checks++;
        if ({s2, s1, s0} !== 3'(exp_ch) || ack !== (8'd1 << exp_ch) || valid !== 1'b1) begin
          failures++;
          $display("FAIL wrap_order st=%0d: sel=%0d ack=%b valid=%b required %0d %b 1",
                   st, {s2, s1, s0}, ack, valid, exp_ch, 8'd1 << exp_ch);
        end
      end
    end
    for (int c = 0; c < 4; c++) cyc(8'd0, 8'd0);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_end: valid=%b required 0", valid);
    end
    $display("test_wrap done");
  endtask

  task automatic test_async_reset();
    cyc(8'h10, 8'hFF);
    checks++;
    if (valid !== 1'b1 || {s2, s1, s0} !== 3'd4) begin
      failures++;
      $display("FAIL areset_pre: valid=%b sel=%0d required 1 4", valid, {s2, s1, s0});
    end
    req = 8'd0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, m, s2, s1, s0, ack, busy} !== 14'd0) begin
      failures++;
      $display("FAIL areset_mid: valid=%b m=%b sel=%0d ack=%b busy=%b required all 0",
               valid, m, {s2, s1, s0}, ack, busy);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(8'hFF, 8'h01);
    checks++;
    if ({s2, s1, s0} !== 3'd0 || ack !== 8'h01 || m !== 1'b1) begin
      failures++;
      $display("FAIL areset_after: sel=%0d ack=%b m=%b required 0 00000001 1", {s2, s1, s0}, ack, m);
    end
    for (int c = 0; c < 4; c++) cyc(8'd0, 8'd0);
    $display("test_async_reset done");
  endtask

  task automatic test_hold1();
    logic [15:0] d;
    int exp_ch;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      d = 16'($urandom);
      @(negedge clk);
      req1 = 8'b0000_1100; din1 = d;
      @(posedge clk);
      #1;
      exp_ch = (k % 2 == 0) ? 2 : 3;
      checks++;
      if (valid1 !== 1'b1 || {s2_1, s1_1, s0_1} !== 3'(exp_ch) ||
          ack1 !== (8'd1 << exp_ch) || m1 !== d[exp_ch*2 +: 2]) begin
        failures++;
        $display("FAIL hold1 k=%0d: valid=%b sel=%0d ack=%b m=%b required 1 %0d %b %b",
                 k, valid1, {s2_1, s1_1, s0_1}, ack1, m1, exp_ch, 8'd1 << exp_ch, d[exp_ch*2 +: 2]);
      end
    end
    @(negedge clk);
    req1 = 8'd0;
    @(posedge clk);
    #1;
    checks++;
    if (valid1 !== 1'b0 || ack1 !== 8'd0) begin
      failures++;
      $display("FAIL hold1_end: valid=%b ack=%b required 0 00000000", valid1, ack1);
    end
    $display("test_hold1 done");
  endtask

  task automatic test_random();
    logic [7:0] r, d;
    int errs;
    do_reset();
    errs = 0;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 3) == 0) ? 8'd0 : (8'($urandom) & 8'($urandom));
      d = 8'($urandom);
      cyc(r, d);
      checks++;
      if (valid !== mdl_active || busy !== mdl_active || m !== mdl_m ||
          {s2, s1, s0} !== 3'(mdl_ch) || ack !== mdl_ack) begin
        failures++;
        errs++;
        if (errs <= 10)
          $display("FAIL random k=%0d: valid=%b m=%b sel=%0d ack=%b required %b %b %0d %b",
                   k, valid, m, {s2, s1, s0}, ack, mdl_active, mdl_m, mdl_ch, mdl_ack);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rr_all();
    test_din_sample();
    test_wrap();
    test_async_reset();
    test_hold1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
